// File: rtl/gate_tt_checker.sv
// gate_tt_checker
// Stimulus/response checker for a two-input gate array. A start pulse
// launches a sweep over the four operand pairs (a,b) = 00, 01, 10, 11.
// Each pair is held for SETTLE_CYCLES+2 cycles. The eight gate outputs are
// sampled in the last of those cycles and compared against the truth table.
// The block reports a pass flag, a saturating count of failing vectors and a
// sticky per-output fail mask.
//
// Optional feature: define GATE_CHECK_STOP_ON_FAIL_EN to end the sweep at the
// first failing vector. Without it, all four vectors always run.
//
// Parameters:
//   SETTLE_CYCLES  extra wait cycles between an operand change and sampling (>=0)
//   ERR_W          width of the saturating error counter (>=1)
// Ports:
//   clk_in         clock, rising edge
//   rst_n_in       synchronous active-low reset
//   start_in       start-sweep pulse, accepted only in IDLE
//   a_out, b_out   registered operands to the gate block
//   and_in .. xnor_in  gate-block outputs under test
//   busy_out       high while the sweep is in SETTLE/CHECK
//   done_out       one-cycle pulse at the end of the sweep
//   pass_out       1 = last sweep had no mismatch; held until the next start
//   err_cnt_out    number of vectors with at least one mismatch (saturating)
//   fail_mask_out  sticky OR of the mismatching outputs
//                  bit order {xnor,nor,nand,bnot,anot,xor,or,and}

module gate_tt_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  output logic             a_out,
  output logic             b_out,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             xor_in,
  input  logic             anot_in,
  input  logic             bnot_in,
  input  logic             nand_in,
  input  logic             nor_in,
  input  logic             xnor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [ERR_W-1:0] err_cnt_out,
  output logic [7:0]       fail_mask_out
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       vec_q;
  logic [CNT_W-1:0] cnt_q;

  logic [7:0] expected;
  logic [7:0] actual;
  logic [7:0] mismatch;
  logic [7:0] mask_next;

  // Truth-table reference for the current vector and the observed outputs,
  // both packed in fail-mask bit order.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a value on
    // every path (defaults first), otherwise synthesis infers a latch.
    expected  = '0;
    actual    = '0;
    mismatch  = '0;
    mask_next = '0;

    expected[0] = vec_q[1] & vec_q[0];
    expected[1] = vec_q[1] | vec_q[0];
    expected[2] = vec_q[1] ^ vec_q[0];
    expected[3] = ~vec_q[1];
    expected[4] = ~vec_q[0];
    expected[5] = ~(vec_q[1] & vec_q[0]);
    expected[6] = ~(vec_q[1] | vec_q[0]);
    expected[7] = ~(vec_q[1] ^ vec_q[0]);

    actual    = {xnor_in, nor_in, nand_in, bnot_in, anot_in, xor_in, or_in, and_in};
    mismatch  = actual ^ expected;
    mask_next = fail_mask_out | mismatch;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_in) state_d = SETTLE;
      SETTLE: if (cnt_q == '0) state_d = CHECK;
      CHECK: begin
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        if (vec_q == 2'd3 || mismatch != 8'h00) state_d = DONE;
        else                                    state_d = SETTLE;
`else
        if (vec_q == 2'd3) state_d = DONE;
        else               state_d = SETTLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Datapath: operands, settle counter and result registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      vec_q         <= 2'd0;
      cnt_q         <= '0;
      a_out         <= 1'b0;
      b_out         <= 1'b0;
      pass_out      <= 1'b0;
      err_cnt_out   <= '0;
      fail_mask_out <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            vec_q         <= 2'd0;
            cnt_q         <= SETTLE_LOAD;
            a_out         <= 1'b0;
            b_out         <= 1'b0;
            pass_out      <= 1'b0;
            err_cnt_out   <= '0;
            fail_mask_out <= 8'h00;
          end
        end
        SETTLE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        CHECK: begin
          fail_mask_out <= mask_next;
          if (mismatch != 8'h00 && err_cnt_out != '1)
            err_cnt_out <= err_cnt_out + ERR_W'(1);
          if (state_d == DONE) begin
            // Pass is decided on the mask including this final vector, so it
            // becomes visible together with done_out.
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            pass_out <= (mask_next == 8'h00);
          end else begin
            vec_q          <= vec_q + 2'd1;
            cnt_q          <= SETTLE_LOAD;
            {a_out, b_out} <= vec_q + 2'd1;
          end
        end
        default: ;  // DONE: results and operands are already final
      endcase
    end
  end

  assign busy_out = (state_q == SETTLE) || (state_q == CHECK);
  assign done_out = (state_q == DONE);

endmodule

// File: tb/tb_gate_tt_checker.sv
// Testbench for gate_tt_checker. A fault-injectable gate model answers the
// DUT's operands. A cycle-indexed model predicts every output from the time
// elapsed since the accepted start. Directed tests pin the model with
// hand-computed literals. A second instance with ERR_W=1 faces a fully
// inverted gate block.

module tb_gate_tt_checker;

  localparam int S    = 2;
  localparam int P    = S + 2;  // cycles per vector
  localparam int EMAX = 15;     // all-ones for ERR_W=4

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic start_in = 1'b0;

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ideal(input logic a, input logic b);
    return {~(a ^ b), ~(a | b), ~(a & b), ~b, ~a, a ^ b, a | b, a & b};
  endfunction

  // Main DUT and its fault-injectable gate block
  logic       a_out, b_out, busy_out, done_out, pass_out;
  logic [3:0] err_cnt_out;
  logic [7:0] fail_mask_out;
  logic [7:0] f_inv = 8'h00, f_s0 = 8'h00, f_s1 = 8'h00;
  logic [7:0] gate_bits;

  assign gate_bits = ((ideal(a_out, b_out) ^ f_inv) & ~f_s0) | f_s1;

  gate_tt_checker #(.SETTLE_CYCLES(S), .ERR_W(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .a_out(a_out), .b_out(b_out),
    .and_in(gate_bits[0]), .or_in(gate_bits[1]), .xor_in(gate_bits[2]),
    .anot_in(gate_bits[3]), .bnot_in(gate_bits[4]), .nand_in(gate_bits[5]),
    .nor_in(gate_bits[6]), .xnor_in(gate_bits[7]),
    .busy_out(busy_out), .done_out(done_out), .pass_out(pass_out),
    .err_cnt_out(err_cnt_out), .fail_mask_out(fail_mask_out)
  );

  // ERR_W=1 instance against a fully inverted gate block
  logic       a_w1, b_w1, busy_w1, done_w1, pass_w1;
  logic [0:0] err_w1;
  logic [7:0] mask_w1;
  logic [7:0] gate_w1;

  assign gate_w1 = ~ideal(a_w1, b_w1);

  gate_tt_checker #(.SETTLE_CYCLES(S), .ERR_W(1)) dut_w1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .a_out(a_w1), .b_out(b_w1),
    .and_in(gate_w1[0]), .or_in(gate_w1[1]), .xor_in(gate_w1[2]),
    .anot_in(gate_w1[3]), .bnot_in(gate_w1[4]), .nand_in(gate_w1[5]),
    .nor_in(gate_w1[6]), .xnor_in(gate_w1[7]),
    .busy_out(busy_w1), .done_out(done_w1), .pass_out(pass_w1),
    .err_cnt_out(err_w1), .fail_mask_out(mask_w1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. The sweep is described by n, the number of cycles
  // since the accepted start. Vector n/P is on the operands, and n/P vectors
  // have been scored.
  logic       model_valid = 1'b0;
  logic       m_active    = 1'b0;
  int         m_n         = 0;
  int         m_nchk      = 4;
  int         m_done_n    = 4 * P;
  logic [7:0] m_mm [4];
  logic       m_held_pass = 1'b0;
  int         m_held_err  = 0;
  logic [7:0] m_held_mask = 8'h00;

  function automatic int part_err(input int k);
    int c = 0;
    for (int v = 0; v < k; v++) if (m_mm[v] != 8'h00) c++;
    return (c > EMAX) ? EMAX : c;
  endfunction

  function automatic logic [7:0] part_mask(input int k);
    logic [7:0] m = 8'h00;
    for (int v = 0; v < k; v++) m |= m_mm[v];
    return m;
  endfunction

  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      m_active    = 1'b0;
      m_n         = 0;
      m_held_pass = 1'b0;
      m_held_err  = 0;
      m_held_mask = 8'h00;
      model_valid = 1'b1;
    end else if (m_active) begin
      if (m_n == m_done_n) begin
        m_active    = 1'b0;
        m_held_err  = part_err(m_nchk);
        m_held_mask = part_mask(m_nchk);
        m_held_pass = (m_held_mask == 8'h00);
      end else begin
        m_n++;
      end
    end else if (start_in) begin
      m_active = 1'b1;
      m_n      = 0;
      m_nchk   = 4;
      for (int v = 0; v < 4; v++) begin
        logic [1:0] vv;
        logic [7:0] id;
        vv      = 2'(v);
        id      = ideal(vv[1], vv[0]);
        m_mm[v] = (((id ^ f_inv) & ~f_s0) | f_s1) ^ id;
      end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
      for (int v = 3; v >= 0; v--) if (m_mm[v] != 8'h00) m_nchk = v + 1;
`endif
      m_done_n = m_nchk * P;
    end
  end

  // Compare process: every cycle once the model has seen reset
  always @(negedge clk_in) begin
    if (model_valid) begin
      logic       ea, eb, ebusy, edone, epass;
      int         ecnt, k;
      logic [7:0] emask;
      logic [1:0] kv;
      if (m_active) begin
        if (m_n == m_done_n) begin
          ea = 1'b0; eb = 1'b0; ebusy = 1'b0; edone = 1'b1;
          k = m_nchk;
          epass = (part_mask(k) == 8'h00);
        end else begin
          k  = m_n / P;
          kv = 2'(k);
          ea = kv[1]; eb = kv[0]; ebusy = 1'b1; edone = 1'b0; epass = 1'b0;
        end
        ecnt  = part_err(k);
        emask = part_mask(k);
      end else begin
        ea = 1'b0; eb = 1'b0; ebusy = 1'b0; edone = 1'b0;
        epass = m_held_pass; ecnt = m_held_err; emask = m_held_mask;
      end
      check("cyc_a",    32'(a_out),         32'(ea));
      check("cyc_b",    32'(b_out),         32'(eb));
      check("cyc_busy", 32'(busy_out),      32'(ebusy));
      check("cyc_done", 32'(done_out),      32'(edone));
      check("cyc_pass", 32'(pass_out),      32'(epass));
      check("cyc_err",  32'(err_cnt_out),   32'(ecnt));
      check("cyc_mask", 32'(fail_mask_out), 32'(emask));
    end
  end

  logic [1:0] tr [64];

  // Pulses start from a negedge in IDLE. Returns the number of cycles from
  // the accepting edge to done_out, or -1 if done never came.
  task automatic run_sweep(output int lat);
    lat = -1;
    start_in = 1'b1;
    @(posedge clk_in);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      tr[n] = {a_out, b_out};
      if (done_out) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, ndone, first_done;

    // Reset
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    check("rst_busy", 32'(busy_out),      32'd0);
    check("rst_pass", 32'(pass_out),      32'd0);
    check("rst_err",  32'(err_cnt_out),   32'd0);
    check("rst_mask", 32'(fail_mask_out), 32'd0);
    @(negedge clk_in);

    // Clean sweep: operands 00,01,10,11 held P cycles each, done after 4*P
    run_sweep(lat);
    check("clean_lat",  32'(lat),           32'd16);
    check("clean_pass", 32'(pass_out),      32'd1);
    check("clean_err",  32'(err_cnt_out),   32'd0);
    check("clean_mask", 32'(fail_mask_out), 32'd0);
    check("ab_v0_first", 32'(tr[0]),  32'd0);
    check("ab_v0_last",  32'(tr[3]),  32'd0);
    check("ab_v1_first", 32'(tr[4]),  32'd1);
    check("ab_v1_last",  32'(tr[7]),  32'd1);
    check("ab_v2_first", 32'(tr[8]),  32'd2);
    check("ab_v3_first", 32'(tr[12]), 32'd3);
    check("ab_v3_last",  32'(tr[15]), 32'd3);
    check("ab_done",     32'(tr[16]), 32'd0);
    // ERR_W=1 instance, everything inverted: counter saturates at 1
    check("w1_err",  32'(err_w1),  32'd1);
    check("w1_mask", 32'(mask_w1), 32'hFF);
    check("w1_pass", 32'(pass_w1), 32'd0);

    // Back-to-back: start in the first IDLE cycle after DONE
    @(negedge clk_in);
    run_sweep(lat);
    check("b2b_lat",  32'(lat),      32'd16);
    check("b2b_pass", 32'(pass_out), 32'd1);

    // xor stuck at 0: mismatch at v=1 and v=2
    @(negedge clk_in);
    f_s0 = 8'h04;
    @(negedge clk_in);
    run_sweep(lat);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    check("xor_lat", 32'(lat),         32'd8);
    check("xor_err", 32'(err_cnt_out), 32'd1);
`else
    check("xor_lat", 32'(lat),         32'd16);
    check("xor_err", 32'(err_cnt_out), 32'd2);
`endif
    check("xor_mask", 32'(fail_mask_out), 32'h04);
    check("xor_pass", 32'(pass_out),      32'd0);
    f_s0 = 8'h00;

    // Start re-pulsed mid-sweep and in the DONE cycle: ignored
    @(negedge clk_in);
    ndone = 0;
    first_done = -1;
    start_in = 1'b1;
    @(posedge clk_in);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_in);
      if (done_out) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      start_in = (n == 2 || n == 9 || n == 16) ? 1'b1 : 1'b0;
    end
    start_in = 1'b0;
    check("ign_ndone", 32'(ndone),      32'd1);
    check("ign_lat",   32'(first_done), 32'd16);

    // One-cycle reset mid-sweep: outputs at reset values, no done pulse
    start_in = 1'b1;
    @(posedge clk_in);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_in);
      start_in = 1'b0;
    end
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    check("mid_a",    32'({a_out, b_out}), 32'd0);
    check("mid_busy", 32'(busy_out),       32'd0);
    check("mid_done", 32'(done_out),       32'd0);
    check("mid_pass", 32'(pass_out),       32'd0);
    check("mid_err",  32'(err_cnt_out),    32'd0);
    check("mid_mask", 32'(fail_mask_out),  32'd0);
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_in);
      if (done_out) ndone++;
    end
    check("mid_nodone", 32'(ndone), 32'd0);
    run_sweep(lat);
    check("post_rst_lat",  32'(lat),      32'd16);
    check("post_rst_pass", 32'(pass_out), 32'd1);

    // and stuck at 1: mismatch at v=0,1,2
    @(negedge clk_in);
    f_s1 = 8'h01;
    @(negedge clk_in);
    run_sweep(lat);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    check("and_lat", 32'(lat),         32'd4);
    check("and_err", 32'(err_cnt_out), 32'd1);
`else
    check("and_lat", 32'(lat),         32'd16);
    check("and_err", 32'(err_cnt_out), 32'd3);
`endif
    check("and_mask", 32'(fail_mask_out), 32'h01);
    check("and_pass", 32'(pass_out),      32'd0);
    f_s1 = 8'h00;

    repeat (3) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
